// File: rtl/xcel_byte_streamer_if.sv
`default_nettype none
// ============================================================================
// Module   : xcel_byte_streamer_if
// Brief    : Command, burst-read and element-stream bundle for the byte streamer
// Revision : 1.0
// ============================================================================
interface xcel_byte_streamer_if #(
    parameter int AXI_AWIDTH = 32,
    parameter int AXI_DWIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [AXI_AWIDTH-1:0] cmd_addr;
    logic [31:0]           cmd_count;

    logic                  read_request_valid;
    logic                  read_request_ready;
    logic [AXI_AWIDTH-1:0] read_addr;
    logic [31:0]           read_len;
    logic [2:0]            read_size;
    logic [1:0]            read_burst;

    logic [AXI_DWIDTH-1:0] read_data;
    logic                  read_data_valid;
    logic                  read_data_ready;

    logic                  elem_valid;
    logic                  elem_ready;
    logic [7:0]            elem_data;
    logic                  elem_last;
    logic                  idle;

    // Streamer side
    modport master (
        input  cmd_valid, cmd_addr, cmd_count,
        input  read_request_ready, read_data, read_data_valid, elem_ready,
        output cmd_ready, read_request_valid, read_addr, read_len, read_size, read_burst,
        output read_data_ready, elem_valid, elem_data, elem_last, idle
    );

    // Command source, memory and consumer side
    modport slave (
        output cmd_valid, cmd_addr, cmd_count,
        output read_request_ready, read_data, read_data_valid, elem_ready,
        input  cmd_ready, read_request_valid, read_addr, read_len, read_size, read_burst,
        input  read_data_ready, elem_valid, elem_data, elem_last, idle
    );
endinterface
`default_nettype wire

// File: rtl/xcel_byte_streamer.sv
`default_nettype none
// ============================================================================
// Module   : xcel_byte_streamer
// Brief    : Byte-addressed command -> INCR burst reads -> one byte per cycle
// Revision : 1.0
// ============================================================================
module xcel_byte_streamer #(
    parameter int AXI_AWIDTH = 32,
    parameter int AXI_DWIDTH = 32,
    parameter int MAX_BURST  = 256
) (
    input  wire logic             clk,
    input  wire logic             rst,
    xcel_byte_streamer_if.master  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DATA  = 2'd2,
        S_DRAIN = 2'd3
    } t_state;

    localparam logic [32:0] c_MAX_BEATS = 33'(MAX_BURST);
    localparam logic [31:0] c_MAX_LEN   = 32'(MAX_BURST - 1);

    t_state                r_state;
    logic                  r_idle;
    logic                  r_req_valid;
    logic [AXI_AWIDTH-1:0] r_read_addr;
    logic [31:0]           r_read_len;
    logic [AXI_AWIDTH-1:0] r_addr;
    logic [32:0]           r_beats;
    logic [8:0]            r_burst_cnt;

    logic [AXI_DWIDTH-1:0] r_buf;
    logic                  r_buf_full;
    logic [1:0]            r_ptr;
    logic [1:0]            r_offset;
    logic                  r_first;
    logic [31:0]           r_rem;

    logic                  w_cmd_hs;
    logic                  w_elem_hs;
    logic                  w_release;
    logic                  w_data_ready;
    logic                  w_data_hs;
    logic [32:0]           w_cmd_beats;
    logic [8:0]            w_burst_beats;
    logic [32:0]           w_beats_next;
    logic [AXI_AWIDTH-1:0] w_addr_next;
    logic [AXI_AWIDTH-1:0] w_cmd_word_addr;

    function automatic logic [31:0] f_len(input logic [32:0] beats);
        if (beats >= c_MAX_BEATS) begin
            return c_MAX_LEN;
        end else begin
            return beats[31:0] - 32'd1;
        end
    endfunction

    assign w_cmd_hs        = r_idle && bus.cmd_valid && (bus.cmd_count != 32'd0);
    assign w_elem_hs       = r_buf_full && bus.elem_ready;
    assign w_release       = w_elem_hs && ((r_ptr == 2'd3) || (r_rem == 32'd1));
    // A word may land in the same edge that frees the buffer, so words stream with no bubble
    assign w_data_ready    = (r_state == S_DATA) && (r_burst_cnt != 9'd0)
                             && (!r_buf_full || w_release);
    assign w_data_hs       = w_data_ready && bus.read_data_valid;
    // 33-bit sum so offset + count + 3 cannot wrap
    assign w_cmd_beats     = ({1'b0, bus.cmd_count} + {31'b0, bus.cmd_addr[1:0]} + 33'd3) >> 2;
    assign w_cmd_word_addr = {bus.cmd_addr[AXI_AWIDTH-1:2], 2'b00};
    assign w_burst_beats   = r_read_len[8:0] + 9'd1;
    assign w_beats_next    = r_beats - {24'b0, w_burst_beats};
    assign w_addr_next     = r_addr + {{(AXI_AWIDTH-11){1'b0}}, w_burst_beats, 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_idle      <= 1'b1;
            r_req_valid <= 1'b0;
            r_read_addr <= '0;
            r_read_len  <= '0;
            r_addr      <= '0;
            r_beats     <= '0;
            r_burst_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_hs) begin
                        r_addr      <= w_cmd_word_addr;
                        r_beats     <= w_cmd_beats;
                        r_read_addr <= w_cmd_word_addr;
                        r_read_len  <= f_len(w_cmd_beats);
                        r_req_valid <= 1'b1;
                        r_idle      <= 1'b0;
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.read_request_ready) begin
                        r_req_valid <= 1'b0;
                        r_burst_cnt <= w_burst_beats;
                        r_state     <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_data_hs) begin
                        r_burst_cnt <= r_burst_cnt - 9'd1;
                        if (r_burst_cnt == 9'd1) begin
                            r_beats <= w_beats_next;
                            r_addr  <= w_addr_next;
                            if (w_beats_next != 33'd0) begin
                                r_read_addr <= w_addr_next;
                                r_read_len  <= f_len(w_beats_next);
                                r_req_valid <= 1'b1;
                                r_state     <= S_REQ;
                            end else begin
                                r_state <= S_DRAIN;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (!r_buf_full || w_release) begin
                        r_idle  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_ptr      <= 2'd0;
            r_offset   <= 2'd0;
            r_first    <= 1'b0;
            r_rem      <= 32'd0;
        end else begin
            if (w_cmd_hs) begin
                r_rem    <= bus.cmd_count;
                r_offset <= bus.cmd_addr[1:0];
                r_first  <= 1'b1;
            end
            if (w_elem_hs) begin
                r_ptr <= r_ptr + 2'd1;
                r_rem <= r_rem - 32'd1;
            end
            if (w_release) begin
                r_buf_full <= 1'b0;
            end
            // Load wins over release and pointer advance in the same edge
            if (w_data_hs) begin
                r_buf      <= bus.read_data;
                r_buf_full <= 1'b1;
                r_ptr      <= r_first ? r_offset : 2'd0;
                r_first    <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready          = r_idle;
    assign bus.idle               = r_idle;
    assign bus.read_request_valid = r_req_valid;
    assign bus.read_addr          = r_read_addr;
    assign bus.read_len           = r_read_len;
    assign bus.read_size          = 3'd2;
    assign bus.read_burst         = 2'b01;
    assign bus.read_data_ready    = w_data_ready;
    assign bus.elem_valid         = r_buf_full;
    assign bus.elem_data          = r_buf[{r_ptr, 3'b000} +: 8];
    assign bus.elem_last          = r_buf_full && (r_rem == 32'd1);
endmodule
`default_nettype wire

// File: tb/tb_xcel_byte_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_xcel_byte_streamer
// Brief    : Directed bench for xcel_byte_streamer with memory and consumer models
// Revision : 1.0
// ============================================================================
module tb_xcel_byte_streamer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    xcel_byte_streamer_if #(.AXI_AWIDTH(32), .AXI_DWIDTH(32)) bus ();

    xcel_byte_streamer #(.AXI_AWIDTH(32), .AXI_DWIDTH(32), .MAX_BURST(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] mem [0:1023];
    bit          mem_rand  = 1'b0;
    bit          cons_rand = 1'b0;
    int          cyc = 0;
    int          stab_err = 0;
    logic [7:0]  elem_q[$];
    bit          last_q[$];
    int          cyc_q[$];
    logic [31:0] req_addr_q[$];
    logic [31:0] req_len_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[11:2]];
        return w[{a[1:0], 3'b000} +: 8];
    endfunction

    task automatic clear_logs();
        elem_q.delete(); last_q.delete(); cyc_q.delete();
        req_addr_q.delete(); req_len_q.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_cmd_ready"}, bus.cmd_ready, 1);
        check_eq({tag, "_idle"}, bus.idle, 1);
        check_eq({tag, "_req_valid"}, bus.read_request_valid, 0);
        check_eq({tag, "_data_ready"}, bus.read_data_ready, 0);
        check_eq({tag, "_elem_valid"}, bus.elem_valid, 0);
        check_eq({tag, "_elem_last"}, bus.elem_last, 0);
        check_eq({tag, "_read_addr"}, bus.read_addr, 0);
        check_eq({tag, "_read_len"}, bus.read_len, 0);
        check_eq({tag, "_elem_data"}, bus.elem_data, 0);
        check_eq({tag, "_size_burst"}, {bus.read_size, bus.read_burst}, {3'd2, 2'b01});
    endtask

    // Memory: accepts one request, then returns len+1 consecutive words
    initial begin : p_mem
        int          beats_left;
        logic [31:0] cur;
        logic [31:0] a_smp;
        logic [31:0] l_smp;
        bit          hs_req;
        bit          hs_dat;
        beats_left = 0;
        cur        = 0;
        bus.read_request_ready = 1'b0;
        bus.read_data_valid    = 1'b0;
        bus.read_data          = '0;
        forever begin
            @(negedge clk);
            hs_req = bus.read_request_valid && bus.read_request_ready;
            hs_dat = bus.read_data_valid && bus.read_data_ready;
            a_smp  = bus.read_addr;
            l_smp  = bus.read_len;
            @(posedge clk);
            #1;
            if (!rst) begin
                beats_left             = 0;
                bus.read_request_ready = 1'b0;
                bus.read_data_valid    = 1'b0;
            end else begin
                if (hs_req) begin
                    req_addr_q.push_back(a_smp);
                    req_len_q.push_back(l_smp);
                    cur        = a_smp;
                    beats_left = int'(l_smp) + 1;
                end
                if (hs_dat) begin
                    cur        = cur + 32'd4;
                    beats_left = beats_left - 1;
                end
                bus.read_data_valid    = (beats_left > 0);
                bus.read_data          = mem[cur[11:2]];
                bus.read_request_ready = mem_rand ? ($urandom_range(0, 2) == 0) : 1'b1;
            end
        end
    end

    // Consumer: logs element handshakes and watches hold-stability under stall
    initial begin : p_cons
        bit         stall;
        logic [7:0] held;
        stall = 1'b0;
        held  = '0;
        bus.elem_ready = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst && stall && (!bus.elem_valid || bus.elem_data !== held)) stab_err++;
            if (rst && bus.elem_valid && bus.elem_ready) begin
                elem_q.push_back(bus.elem_data);
                last_q.push_back(bus.elem_last);
                cyc_q.push_back(cyc);
            end
            stall = rst && bus.elem_valid && !bus.elem_ready;
            held  = bus.elem_data;
            @(posedge clk);
            #1;
            bus.elem_ready = cons_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    task automatic send_cmd(input logic [31:0] addr, input logic [31:0] cnt);
        int ok;
        ok = 0;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = addr;
        bus.cmd_count = cnt;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        check_eq("cmd_accept", ok, 1);
    endtask

    task automatic wait_done(input int n, input int budget, input string tag);
        int ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (elem_q.size() >= n && bus.idle) begin
                ok = 1;
                break;
            end
        end
        check_eq({tag, "_done"}, ok, 1);
    endtask

    task automatic run_aligned(input string tag);
        logic [7:0] exp_al [8];
        exp_al = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h85, 8'h86, 8'h87, 8'h88};
        clear_logs();
        send_cmd(32'h000, 32'd8);
        @(negedge clk);
        check_eq({tag, "_req_latency"}, bus.read_request_valid, 1);
        wait_done(8, 200, tag);
        check_eq({tag, "_nreq"}, req_addr_q.size(), 1);
        check_eq({tag, "_req0"}, {req_addr_q[0], req_len_q[0]}, {32'h000, 32'd1});
        check_eq({tag, "_nelem"}, elem_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("%s_elem%0d", tag, i), {elem_q[i], 7'd0, last_q[i]},
                     {exp_al[i], 7'd0, (i == 7)});
        end
        check_eq({tag, "_back_to_back"}, cyc_q[7] - cyc_q[0], 7);
    endtask

    initial begin : p_main
        int errs;
        int seen;
        logic [7:0] exp5 [5];
        logic [7:0] exp4 [4];
        logic [31:0] exp_ra [3];
        logic [31:0] exp_rl [3];

        for (int i = 0; i < 1024; i++) begin
            for (int b = 0; b < 4; b++) mem[i][8*b +: 8] = 8'((4*i + b) * 13 + 7);
        end
        mem[0]     = 32'h04030201;
        mem[1]     = 32'h88878685;
        mem[4]     = 32'hDEADBEEF;
        mem[10'h40] = 32'hA1B2C3D4;
        mem[10'h41] = 32'h11223344;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_count = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("rst");
        rst = 1'b1;

        run_aligned("aligned");

        // Unaligned: byte 3 of word 0x100, then word 0x104
        exp5 = '{8'hA1, 8'h44, 8'h33, 8'h22, 8'h11};
        clear_logs();
        send_cmd(32'h103, 32'd5);
        wait_done(5, 200, "unal");
        check_eq("unal_nreq", req_addr_q.size(), 1);
        check_eq("unal_req0", {req_addr_q[0], req_len_q[0]}, {32'h100, 32'd1});
        check_eq("unal_nelem", elem_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("unal_elem%0d", i), {elem_q[i], 7'd0, last_q[i]},
                     {exp5[i], 7'd0, (i == 4)});
        end

        // Multi-burst with MAX_BURST=64: 150 beats -> 64 + 64 + 22
        exp_ra = '{32'h200, 32'h300, 32'h400};
        exp_rl = '{32'd63, 32'd63, 32'd21};
        clear_logs();
        send_cmd(32'h200, 32'd600);
        wait_done(600, 5000, "multi");
        check_eq("multi_nreq", req_addr_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("multi_req%0d", i), {req_addr_q[i], req_len_q[i]},
                     {exp_ra[i], exp_rl[i]});
        end
        check_eq("multi_nelem", elem_q.size(), 600);
        errs = 0;
        for (int i = 0; i < elem_q.size(); i++) begin
            if (elem_q[i] !== mem_byte(32'h200 + 32'(i)) || last_q[i] !== (i == 599)) errs++;
        end
        check_eq("multi_data_errs", errs, 0);
        check_eq("multi_idle", bus.idle, 1);

        // Backpressure on both sides
        mem_rand  = 1'b1;
        cons_rand = 1'b1;
        stab_err  = 0;
        clear_logs();
        send_cmd(32'h081, 32'd16);
        wait_done(16, 2000, "bp");
        check_eq("bp_req0", {req_addr_q[0], req_len_q[0]}, {32'h080, 32'd4});
        check_eq("bp_nelem", elem_q.size(), 16);
        errs = 0;
        for (int i = 0; i < elem_q.size(); i++) begin
            if (elem_q[i] !== mem_byte(32'h081 + 32'(i)) || last_q[i] !== (i == 15)) errs++;
        end
        check_eq("bp_data_errs", errs, 0);
        check_eq("bp_stability_errs", stab_err, 0);
        mem_rand  = 1'b0;
        cons_rand = 1'b0;
        repeat (2) @(posedge clk);

        // Zero count, then a normal 4-byte command
        clear_logs();
        send_cmd(32'h040, 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.read_request_valid || !bus.cmd_ready) seen++;
        end
        check_eq("zero_quiet", seen, 0);
        check_eq("zero_no_elem", elem_q.size() + req_addr_q.size(), 0);
        exp4 = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_cmd(32'h010, 32'd4);
        wait_done(4, 200, "four");
        check_eq("four_req0", {req_addr_q[0], req_len_q[0]}, {32'h010, 32'd0});
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("four_elem%0d", i), {elem_q[i], 7'd0, last_q[i]},
                     {exp4[i], 7'd0, (i == 3)});
        end

        // Asynchronous reset in the middle of a 64-beat burst
        clear_logs();
        send_cmd(32'h000, 32'd256);
        seen = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (elem_q.size() >= 12) begin
                seen = 1;
                break;
            end
        end
        check_eq("midrst_reached_data", {seen[0], bus.read_request_valid, bus.idle}, 3'b100);
        check_eq("midrst_req0", {req_addr_q[0], req_len_q[0]}, {32'h000, 32'd63});
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_reset_values("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        run_aligned("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : p_watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
        $fatal(1);
    end
endmodule
`default_nettype wire
